// File: rtl/aes_pkg.sv
// Shared definitions for the AES S-box responder: forward/inverse S-box
// tables, the responder FSM state type and the legal LATENCY range.
package aes_pkg;

    // Legal range of the responder LATENCY parameter.
    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 4;

    // Width of the latency down-counter (holds LATENCY-1, at most 3).
    localparam int LAT_CNT_W = 2;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        DATA,
        RELEASE
    } rsp_state_e;

    localparam logic [7:0] SBOX_FWD [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] SBOX_INV [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

endpackage

// File: rtl/aes_sbox_responder_if.sv
// Request/response bundle between the AES round engine (master) and the
// S-box responder (slave): address handshake, data handshake, served count.
interface aes_sbox_responder_if;

    logic        addr_req;
    logic [7:0]  req_addr;
    logic        req_inv;
    logic        data_ack;
    logic        addr_ack;
    logic        data_valid;
    logic [7:0]  sbox_read_data;
    logic [15:0] served_cnt;

    modport master (
        output addr_req,
        output req_addr,
        output req_inv,
        output data_ack,
        input  addr_ack,
        input  data_valid,
        input  sbox_read_data,
        input  served_cnt
    );

    modport slave (
        input  addr_req,
        input  req_addr,
        input  req_inv,
        input  data_ack,
        output addr_ack,
        output data_valid,
        output sbox_read_data,
        output served_cnt
    );

endinterface

// File: rtl/aes_sbox_rom.sv
// Registered S-box ROM: one-cycle read of the forward or inverse table.
// Ports: clk_i, addr_i (index), inv_i (1 = inverse table), data_o (registered).
module aes_sbox_rom
    import aes_pkg::*;
(
    input  logic       clk_i,
    input  logic [7:0] addr_i,
    input  logic       inv_i,
    output logic [7:0] data_o
);

    logic [7:0] data_q;

    always_ff @(posedge clk_i) begin
        data_q <= inv_i ? SBOX_INV[addr_i] : SBOX_FWD[addr_i];
    end

    assign data_o = data_q;

endmodule

// File: rtl/aes_sbox_responder.sv
// S-box server for the AES round engine: four-phase address/data handshake,
// LATENCY-cycle lookup, fully registered outputs, wrapping served counter.
// Ports: clk, rst (async, active high), bus (slave side of the request bundle).
module aes_sbox_responder
    import aes_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input logic                  clk,
    input logic                  rst,
    aes_sbox_responder_if.slave  bus
);

    if (LATENCY < LAT_MIN || LATENCY > LAT_MAX) begin : g_bad_latency
        $error("aes_sbox_responder: LATENCY must be within 1..4");
    end

    localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(LATENCY - 1);

    rsp_state_e           state_q, state_d;
    logic [LAT_CNT_W-1:0] lat_q, lat_d;
    logic [7:0]           addr_q, addr_d;
    logic                 inv_q, inv_d;
    logic                 ack_q, ack_d;
    logic                 dv_q, dv_d;
    logic [7:0]           data_q, data_d;
    logic [15:0]          served_q, served_d;

    logic [7:0]           rom_addr;
    logic                 rom_inv;
    logic [7:0]           rom_data;

    // In IDLE the ROM reads the live request so that its register already
    // holds the answer one edge after acceptance; afterwards it keeps reading
    // the latched request, so later req_addr changes have no effect.
    assign rom_addr = (state_q == IDLE) ? bus.req_addr : addr_q;
    assign rom_inv  = (state_q == IDLE) ? bus.req_inv  : inv_q;

    aes_sbox_rom u_rom (
        .clk_i  (clk),
        .addr_i (rom_addr),
        .inv_i  (rom_inv),
        .data_o (rom_data)
    );

    always_comb begin
        state_d  = state_q;
        lat_d    = lat_q;
        addr_d   = addr_q;
        inv_d    = inv_q;
        ack_d    = ack_q;
        dv_d     = dv_q;
        data_d   = data_q;
        served_d = served_q;

        unique case (state_q)
            IDLE: begin
                if (bus.addr_req) begin
                    addr_d  = bus.req_addr;
                    inv_d   = bus.req_inv;
                    ack_d   = 1'b1;
                    lat_d   = LAT_LOAD;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                // A release by the requester wins over a completing lookup.
                if (!bus.addr_req) begin
                    ack_d   = 1'b0;
                    lat_d   = '0;
                    state_d = IDLE;
                end else if (lat_q == '0) begin
                    data_d  = rom_data;
                    dv_d    = 1'b1;
                    state_d = DATA;
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            DATA: begin
                if (bus.data_ack) begin
                    dv_d     = 1'b0;
                    served_d = served_q + 16'd1;
                    if (!bus.addr_req) begin
                        ack_d   = 1'b0;
                        state_d = IDLE;
                    end else begin
                        state_d = RELEASE;
                    end
                end else if (!bus.addr_req) begin
                    dv_d    = 1'b0;
                    ack_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            RELEASE: begin
                if (!bus.addr_req) begin
                    ack_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                ack_d   = 1'b0;
                dv_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            lat_q    <= '0;
            addr_q   <= '0;
            inv_q    <= 1'b0;
            ack_q    <= 1'b0;
            dv_q     <= 1'b0;
            data_q   <= '0;
            served_q <= '0;
        end else begin
            state_q  <= state_d;
            lat_q    <= lat_d;
            addr_q   <= addr_d;
            inv_q    <= inv_d;
            ack_q    <= ack_d;
            dv_q     <= dv_d;
            data_q   <= data_d;
            served_q <= served_d;
        end
    end

    assign bus.addr_ack       = ack_q;
    assign bus.data_valid     = dv_q;
    assign bus.sbox_read_data = data_q;
    assign bus.served_cnt     = served_q;

endmodule

// File: tb/tb_aes_sbox_responder.sv
// Self-checking bench for aes_sbox_responder at LATENCY=1 and LATENCY=3,
// against an S-box model derived from GF(2^8) inversion and the affine map.
module tb_aes_sbox_responder;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    logic        a_req  [2];
    logic        a_inv  [2];
    logic        a_dack [2];
    logic [7:0]  a_addr [2];
    logic        o_ack  [2];
    logic        o_dv   [2];
    logic [7:0]  o_data [2];
    logic [15:0] o_cnt  [2];

    aes_sbox_responder_if bus1 ();
    aes_sbox_responder_if bus3 ();

    assign bus1.addr_req = a_req[0];
    assign bus1.req_addr = a_addr[0];
    assign bus1.req_inv  = a_inv[0];
    assign bus1.data_ack = a_dack[0];
    assign bus3.addr_req = a_req[1];
    assign bus3.req_addr = a_addr[1];
    assign bus3.req_inv  = a_inv[1];
    assign bus3.data_ack = a_dack[1];

    assign o_ack[0]  = bus1.addr_ack;
    assign o_dv[0]   = bus1.data_valid;
    assign o_data[0] = bus1.sbox_read_data;
    assign o_cnt[0]  = bus1.served_cnt;
    assign o_ack[1]  = bus3.addr_ack;
    assign o_dv[1]   = bus3.data_valid;
    assign o_data[1] = bus3.sbox_read_data;
    assign o_cnt[1]  = bus3.served_cnt;

    aes_sbox_responder #(.LATENCY(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    aes_sbox_responder #(.LATENCY(3)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3.slave)
    );

    logic [7:0]  fwd_m [256];
    logic [7:0]  inv_m [256];
    logic [15:0] exp_cnt  [2];
    logic [7:0]  exp_data [2];
    int n_chk  = 0;
    int n_fail = 0;

    function automatic int lat(input int s);
        return (s == 0) ? 1 : 3;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xtime(x);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] a);
        if (a == 8'h00) return 8'h00;
        for (int x = 1; x < 256; x++) begin
            if (gmul(a, 8'(x)) == 8'h01) return 8'(x);
        end
        return 8'h00;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int k);
        return 8'((b << k) | (b >> (8 - k)));
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] b);
        return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Request, then walk through the lookup; returns at the negedge where
    // data_valid must have just risen. data_ack is toggled during LOOKUP
    // and must be ignored there.
    task automatic to_data(input int s, input logic [7:0] a, input logic inv);
        logic [7:0] e;
        e = inv ? inv_m[a] : fwd_m[a];
        a_req[s]  = 1'b1;
        a_addr[s] = a;
        a_inv[s]  = inv;
        a_dack[s] = 1'b0;
        @(negedge clk);
        chk("ack_rise", o_ack[s], 1);
        chk("dv_early", o_dv[s], 0);
        a_addr[s] = ~a;
        a_inv[s]  = ~inv;
        a_dack[s] = 1'($urandom % 2);
        for (int i = 1; i < lat(s); i++) begin
            @(negedge clk);
            chk("dv_early", o_dv[s], 0);
        end
        @(negedge clk);
        a_dack[s] = 1'b0;
        chk("dv_rise", o_dv[s], 1);
        chk("data", o_data[s], e);
        chk("ack_hold", o_ack[s], 1);
        chk("cnt_hold", o_cnt[s], exp_cnt[s]);
        exp_data[s] = e;
    endtask

    task automatic txn(input int s, input logic [7:0] a, input logic inv,
                       input int hold, input bit together);
        to_data(s, a, inv);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("dv_hold", o_dv[s], 1);
            chk("data_hold", o_data[s], exp_data[s]);
        end
        a_dack[s] = 1'b1;
        if (together) a_req[s] = 1'b0;
        @(negedge clk);
        exp_cnt[s] = exp_cnt[s] + 16'd1;
        chk("dv_fall", o_dv[s], 0);
        chk("cnt", o_cnt[s], exp_cnt[s]);
        chk("ack_after_dack", o_ack[s], together ? 0 : 1);
        a_dack[s] = 1'b0;
        if (!together) begin
            a_req[s] = 1'b0;
            @(negedge clk);
            chk("ack_fall", o_ack[s], 0);
        end
        chk("data_kept", o_data[s], exp_data[s]);
    endtask

    task automatic abort_lookup(input int s, input logic [7:0] a, input logic inv, input int d);
        a_req[s]  = 1'b1;
        a_addr[s] = a;
        a_inv[s]  = inv;
        @(negedge clk);
        chk("ab_ack_rise", o_ack[s], 1);
        for (int i = 0; i < d; i++) begin
            @(negedge clk);
            chk("ab_dv", o_dv[s], 0);
        end
        a_req[s] = 1'b0;
        @(negedge clk);
        chk("ab_ack_fall", o_ack[s], 0);
        chk("ab_dv", o_dv[s], 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("ab_dv_quiet", o_dv[s], 0);
        end
        chk("ab_cnt", o_cnt[s], exp_cnt[s]);
        chk("ab_data", o_data[s], exp_data[s]);
    endtask

    task automatic abort_data(input int s, input logic [7:0] a, input logic inv);
        to_data(s, a, inv);
        a_req[s] = 1'b0;
        @(negedge clk);
        chk("abd_dv", o_dv[s], 0);
        chk("abd_ack", o_ack[s], 0);
        chk("abd_cnt", o_cnt[s], exp_cnt[s]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) fwd_m[i] = affine(ginv(8'(i)));
        for (int i = 0; i < 256; i++) inv_m[fwd_m[i]] = 8'(i);
        for (int s = 0; s < 2; s++) begin
            a_req[s] = 1'b0; a_inv[s] = 1'b0; a_dack[s] = 1'b0; a_addr[s] = 8'h00;
            exp_cnt[s] = 16'h0000; exp_data[s] = 8'h00;
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            chk("rst_ack", o_ack[s], 0);
            chk("rst_dv", o_dv[s], 0);
            chk("rst_data", o_data[s], 0);
            chk("rst_cnt", o_cnt[s], 0);
        end
        rst = 1'b0;
        @(negedge clk);

        txn(0, 8'h00, 1'b0, 0, 1'b0);
        txn(0, 8'h53, 1'b0, 1, 1'b0);
        txn(1, 8'h53, 1'b0, 0, 1'b0);
        txn(1, 8'hff, 1'b0, 0, 1'b0);
        txn(1, 8'h63, 1'b1, 0, 1'b0);
        txn(1, 8'h00, 1'b1, 2, 1'b0);

        abort_lookup(1, 8'h10, 1'b0, 1);
        abort_lookup(1, 8'h20, 1'b1, 2);
        abort_lookup(0, 8'h30, 1'b0, 0);
        txn(0, 8'h01, 1'b0, 0, 1'b0);
        txn(1, 8'h01, 1'b0, 0, 1'b0);

        txn(0, 8'hc9, 1'b0, 0, 1'b1);
        txn(0, 8'h7c, 1'b1, 0, 1'b1);
        txn(1, 8'hab, 1'b1, 1, 1'b1);
        txn(1, 8'h9a, 1'b0, 0, 1'b0);

        abort_data(0, 8'h44, 1'b0);
        txn(0, 8'h45, 1'b1, 0, 1'b0);
        abort_data(1, 8'h46, 1'b1);

        // Asynchronous reset while dut3 sits in DATA with an ack pending.
        to_data(1, 8'h77, 1'b0);
        a_dack[1] = 1'b1;
        a_req[1]  = 1'b0;
        #2 rst = 1'b1;
        #1;
        for (int s = 0; s < 2; s++) begin
            chk("arst_ack", o_ack[s], 0);
            chk("arst_dv", o_dv[s], 0);
            chk("arst_data", o_data[s], 0);
            chk("arst_cnt", o_cnt[s], 0);
            exp_cnt[s]  = 16'h0000;
            exp_data[s] = 8'h00;
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("arst_dack_ign_cnt", o_cnt[1], 0);
        chk("arst_dack_ign_dv", o_dv[1], 0);
        a_dack[1] = 1'b0;
        txn(1, 8'h77, 1'b0, 0, 1'b0);

        force dut1.served_q = 16'hffff;
        @(negedge clk);
        release dut1.served_q;
        exp_cnt[0] = 16'hffff;
        txn(0, 8'h12, 1'b0, 0, 1'b1);
        chk("wrap", o_cnt[0], 16'h0000);

        for (int k = 0; k < 40; k++) begin
            int s;
            int kind;
            s    = int'($urandom % 2);
            kind = int'($urandom % 6);
            if (kind == 0)
                abort_lookup(s, 8'($urandom), 1'($urandom), int'($urandom % lat(s)));
            else if (kind == 1)
                abort_data(s, 8'($urandom), 1'($urandom));
            else
                txn(s, 8'($urandom), 1'($urandom), int'($urandom % 3), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_sbox_responder.md
# aes_sbox_responder

Memory-side S-box server for the AES datapath. It answers byte lookup requests from the AES round engine over a four-phase address/data handshake and returns the forward or inverse AES S-box value. It sits between the round engine's S-box request port and the S-box ROM.

## Interface
- `LATENCY`, default 1: cycles from address acceptance to data valid; legal range 1..4.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `addr_req` in 1: requester address valid (round engine `flag_address_sent`).
- `req_addr` in 8: S-box index; must be stable while `addr_req`=1.
- `req_inv` in 1: 0 selects the forward S-box, 1 selects the inverse S-box; sampled together with `req_addr`.
- `data_ack` in 1: requester has captured `sbox_read_data`.
- `addr_ack` out 1: address accepted; held until the requester releases.
- `data_valid` out 1: `sbox_read_data` is valid (round engine `flag_data_sent`).
- `sbox_read_data` out 8: lookup result.
- `served_cnt` out 16: number of completed lookups; wraps from 0xFFFF to 0.

## Operation
- Reset values: `addr_ack`=0, `data_valid`=0, `sbox_read_data`=0x00, `served_cnt`=0, FSM=IDLE, latency counter=0.
- FSM states and transitions:
  - IDLE:
    - `addr_req`=1 → latch `req_addr` and `req_inv`, set `addr_ack`=1, load counter with LATENCY-1, go to LOOKUP.
    - `addr_req`=0 → stay in IDLE.
  - LOOKUP:
    - Counter decrements each cycle.
    - When the counter reaches 0, register the ROM output into `sbox_read_data`, set `data_valid`=1, go to DATA.
    - `addr_req` falls while in LOOKUP (abort) → `addr_ack`=0, no data is issued, go to IDLE; `served_cnt` is unchanged.
  - DATA:
    - Hold `sbox_read_data` and `data_valid`.
    - `data_ack`=1 → `data_valid`=0, `served_cnt`+1, go to RELEASE.
    - If `addr_req`=0 in the same cycle as `data_ack`=1 → additionally set `addr_ack`=0 and go to IDLE.
    - `addr_req`=0 while `data_ack`=0 (abort) → `data_valid`=0, `addr_ack`=0, go to IDLE; no count increment.
  - RELEASE:
    - Wait for `addr_req`=0, then set `addr_ack`=0 and go to IDLE.
    - A new request is only accepted from IDLE.
- `data_ack` is ignored outside DATA.
- `sbox_read_data` keeps its last value after the handshake; it changes only at the LOOKUP→DATA transition.
- The latched address is used, so a `req_addr` change after acceptance has no effect.
- Reset asserted mid-operation: all outputs return to their reset values immediately and asynchronously; the in-flight lookup is discarded.
- `served_cnt` is 16-bit unsigned modulo-2^16 arithmetic.

## Timing
- `addr_req` sampled high at edge N → `addr_ack`=1 after edge N.
- `data_valid`=1 and data are valid after edge N+LATENCY.
- `data_ack` sampled at edge M → `data_valid`=0 after edge M; `served_cnt` is updated after edge M.
- Minimum full transaction with the requester releasing `addr_req` on the edge after it sees `data_valid`: LATENCY+2 cycles from request to IDLE; back-to-back issue is possible every LATENCY+3 cycles.
- There is no combinational path from any input to any output; all outputs are registered.

## Structure
- Package `aes_pkg` holds:
  - `SBOX_FWD[256]` and `SBOX_INV[256]` byte constant arrays.
  - The responder FSM state enum (IDLE, LOOKUP, DATA, RELEASE).
  - The `LATENCY` legal-range constants.
- Sub-module `aes_sbox_rom`:
  - Inputs: `clk`, 8-bit addr, `inv` select.
  - Output: registered 8-bit data, read from the package tables.
  - The responder instantiates one copy and times the LOOKUP exit to the ROM register.
- Parameter check: `LATENCY` outside 1..4 is an elaboration error.

## Test plan
- Reset, then forward lookup `req_addr`=0x00, `req_inv`=0, LATENCY=1 → `addr_ack` after 1 edge, `data_valid` with `sbox_read_data`=0x63 after 2 edges; after `data_ack`, `served_cnt`=1.
- Forward 0x53 → 0xED; forward 0xFF → 0x16; inverse 0x63 → 0x00; inverse 0x00 → 0x52; run back-to-back at LATENCY=3 and check `data_valid` exactly 3 edges after acceptance each time.
- Abort: drop `addr_req` during LOOKUP → `addr_ack` falls, `data_valid` never rises, `served_cnt` unchanged, next request 0x01 → 0x7C.
- Same-cycle `data_ack`=1 and `addr_req`=0 in DATA → `data_valid` and `addr_ack` both 0 after that edge, FSM returns to IDLE; a new request on the following cycle is accepted.
- Assert `rst` asynchronously while in DATA → all outputs 0 before the next clock edge; the pending `data_ack` after reset is ignored.
- Preload `served_cnt`=0xFFFF via 65535 transactions, or force it in the bench → next completed lookup wraps the count to 0x0000.
